// File: rtl/seg7_scan_display_if.sv
// Display write bus between the display controller (master) and the scan display (slave).
// Carries the write strobe, the entry address and the 6-bit entry data.
interface seg7_scan_display_if;
  logic       W;
  logic [2:0] WADD;
  logic [5:0] DIN;

  modport master (output W, output WADD, output DIN);
  modport slave  (input  W, input  WADD, input  DIN);
endinterface

// File: rtl/seg7_scan_display.sv
// Eight-entry digit store that time-multiplexes onto an 8-digit common-anode 7-segment display.
// Each digit slot begins with BLANK cycles of all-anodes-off to suppress ghosting.
module seg7_scan_display #(
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned BLANK    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_display_if.slave   bus,
  output logic [7:0]           AN,
  output logic [6:0]           SEG,
  output logic                 DP,
  output logic                 FRAME
);

  localparam int unsigned PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLast  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BlankN = PW'(BLANK);

  logic [PW-1:0] pcnt_q;
  logic [2:0]    dig_q;
  logic [5:0]    mem_q [8];

  logic [5:0] entry;
  logic       lit;
  logic       wrap;
  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;
  logic       frame_d;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_dec(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    entry   = mem_q[dig_q];
    lit     = (pcnt_q >= BlankN) && entry[5];
    wrap    = (pcnt_q == PLast);
    an_d    = lit ? ~(8'b1 << dig_q) : 8'hFF;
    seg_d   = lit ? hex_dec(entry[4:1]) : 7'h7F;
    dp_d    = lit ? entry[0] : 1'b1;
    // Registered alongside the 7->0 index step, so FRAME is high while dig_q is 0.
    frame_d = wrap && (dig_q == 3'd7);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= 6'b000000;
      pcnt_q <= '0;
      dig_q  <= 3'd0;
      AN     <= 8'hFF;
      SEG    <= 7'h7F;
      DP     <= 1'b1;
      FRAME  <= 1'b0;
    end else begin
      if (bus.W) mem_q[bus.WADD] <= bus.DIN;
      pcnt_q <= wrap ? '0 : pcnt_q + 1'b1;
      if (wrap) dig_q <= dig_q + 3'd1;
      AN     <= an_d;
      SEG    <= seg_d;
      DP     <= dp_d;
      FRAME  <= frame_d;
    end
  end

endmodule
